seq_checker: RTL
================

# seq_checker

Sequence checker that consumes the value stream of a free-running modulo-(MAX+1) up-counter and verifies that every sample is the wrapped successor of the previous one. It acquires lock after a run of correct samples. While locked it flags each break with a one-cycle pulse and a saturating error count, and it drops lock after consecutive misses. It sits on the receiving end of the team's counter blocks and serves as an on-chip monitor or bench checker for them.

## Interface

- WIDTH, 2 — width of the sampled count.
- MAX, 3 — terminal value; successor of MAX is 0 (must be ≤ 2^WIDTH−1).
- LOCK_CNT, 4 — consecutive correct samples needed to lock (≥ 2).
- MISS_LIMIT, 2 — consecutive locked-mode mismatches that drop lock (≥ 1).

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  count_in is a sample this cycle.
- count_in  in  WIDTH  sampled counter value.
- clr_err  in  1  clears err_count and err_sticky.
- locked  out  1  checker is locked to the stream.
- err_pulse  out  1  one-cycle flag for a locked-mode mismatch.
- err_count  out  8  locked-mode mismatches, saturating at 255.
- expected  out  WIDTH  value predicted for the next sample.
- err_sticky  out  1  see Configuration.

## Operation

- next(x) = (x < MAX) ? x+1 : 0. Values above MAX are always mismatches, and their next() is 0.
- Cycles with in_valid=0 change no state. err_pulse is 0 in those cycles.
- FSM states:
  - SEARCH (reset state): a valid sample sets expected←next(count_in) and good_cnt←1, then moves to ACQUIRE.
  - ACQUIRE, match: good_cnt++ and expected←next(count_in). Enter LOCKED when good_cnt reaches LOCK_CNT.
  - ACQUIRE, mismatch: reseed with expected←next(count_in) and good_cnt←1. Stay in ACQUIRE. No error is reported.
  - LOCKED, match: miss_cnt←0 and expected←next(count_in).
  - LOCKED, mismatch:
    - err_pulse=1 and err_count increments (saturating).
    - expected←next(count_in) (resync to the observed value).
    - miss_cnt++. When miss_cnt reaches MISS_LIMIT: move to SEARCH, clear miss_cnt and good_cnt, set locked=0.
- locked=1 exactly when the state is LOCKED.
- clr_err together with a counted error in the same cycle gives err_count=1 (clear first, then count).
- err_count holds at 255. Further errors still pulse err_pulse.

## Timing

- All outputs are registered. A sample on edge N is reflected in locked, err_pulse, err_count, expected and err_sticky after edge N.
- Lock latency: locked rises on the edge of the LOCK_CNT-th consecutive correct valid sample, counting from the seeding sample.
- err_pulse is high for exactly one cycle per mismatch, even on back-to-back valid mismatches.
- Reset values: state=SEARCH, locked=0, err_pulse=0, err_count=0, expected=0, err_sticky=0, internal counters=0.
- rst asserted mid-operation overrides every other input on that edge.

## Configuration

- SEQ_CHECKER_STICKY_ERR_EN:
  - Defined: err_sticky goes to 1 on the first locked-mode mismatch. It holds through loss of lock and clears only on clr_err or rst. If clr_err and an error occur in the same cycle, err_sticky is 1.
  - Undefined: err_sticky is tied to 0 and no register is built for it.

## Test plan

All scenarios use WIDTH=2, MAX=3, LOCK_CNT=4, MISS_LIMIT=2.

- Reset, then valid 0,1,2,3: locked=1 after the 4th edge, err_count=0, expected=0.
- Locked, then valid 0,1,3: one-cycle err_pulse after the "3", err_count=1, expected=0, locked stays 1. err_sticky=1 only with the macro defined.
- Locked with expected=2, then valid 0,0: two err_pulses, err_count=2, locked=0 after the second edge, state SEARCH.
- Wrap check: locked, 3 then 0 gives no error; 3 then 1 gives err_pulse and expected=2. Out-of-range handling (needs WIDTH=3, MAX=5): locked, valid 7 gives an error and expected=0.
- Gaps: valid 0,1, then in_valid=0 for 5 cycles, then 2,3: no err_pulse, locked=1 after the "3". Garbage count_in during the gap is ignored.
- Saturation and priority:
  - 300 locked errors, reseeding lock as needed: err_count stays at 255.
  - clr_err in the same cycle as a mismatch: err_count=1.
  - rst while locked: every output reads its reset value after the next edge.

Source files
------------

// File: rtl/seq_checker.sv
// Sequence checker for a free-running modulo-(MAX+1) counter stream.
// Optional sticky error flag is built only when SEQ_CHECKER_STICKY_ERR_EN is defined.
module seq_checker #(
    parameter int unsigned WIDTH      = 2,
    parameter int unsigned MAX        = 3,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] expected,
    output logic             err_sticky
);

    localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);
    localparam int unsigned ERR_W   = 8;

    localparam logic [WIDTH-1:0]  MAX_V   = WIDTH'(MAX);
    localparam logic [GOOD_W-1:0] LOCK_V  = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_V  = MISS_W'(MISS_LIMIT);
    localparam logic [ERR_W-1:0]  ERR_SAT = {ERR_W{1'b1}};

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [GOOD_W-1:0] good_cnt_q,  good_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q,  miss_cnt_d;
    logic [WIDTH-1:0]  expected_q,  expected_d;
    logic              locked_q,    locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;

    logic              match_c;
    logic              mismatch_c;
    logic [WIDTH-1:0]  succ_c;

    // Wrapped successor; anything above MAX restarts the sequence at 0.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        return (x < MAX_V) ? x + WIDTH'(1) : '0;
    endfunction

    assign succ_c     = next_val(count_in);
    assign match_c    = (count_in == expected_q);
    assign mismatch_c = in_valid && (state_q == ST_LOCKED) && !match_c;

    // Next-state logic: every valid sample resyncs the prediction to the observed value.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        expected_d = expected_q;
        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    expected_d = succ_c;
                    good_cnt_d = GOOD_W'(1);
                    state_d    = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    expected_d = succ_c;
                    if (match_c) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_q + GOOD_W'(1) == LOCK_V) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    expected_d = succ_c;
                    if (match_c) begin
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q + MISS_W'(1) == MISS_V) begin
                        state_d    = ST_SEARCH;
                        miss_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MISS_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    // Clear is applied before the current error is counted.
    always_comb begin
        err_pulse_d = mismatch_c;
        err_count_d = clr_err ? '0 : err_count_q;
        if (mismatch_c && (err_count_d != ERR_SAT)) begin
            err_count_d = err_count_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            expected_q  <= expected_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;

`ifdef SEQ_CHECKER_STICKY_ERR_EN
    logic err_sticky_q, err_sticky_d;

    // Set wins over a same-cycle clear; survives loss of lock.
    always_comb begin
        err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
        if (mismatch_c) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule
